// File: rtl/fft_bf_sequencer.sv
// ---------------------------------------------------------------------------
// fft_bf_sequencer
//
// Control block for an in-place 256-point radix-2 DIT FFT whose input data is
// held in bit-reversed order. It walks the N_LOG2 stages. In each stage it
// issues one butterfly per cycle by driving a dual read of the data RAM and a
// twiddle-ROM read. It then tracks each butterfly through the core using a
// small write-address queue, so that every result lands back on the p/q pair
// it was read from. Between stages the pipeline is fully drained. This means a
// stage never reads a location that the previous stage has yet to write.
//
// Optional feature:
//   FFT_SEQ_STALL_EN  when defined, adds input mem_rdy. A butterfly is issued
//                     only in cycles that follow a clock edge where mem_rdy
//                     was 1. Drain and write-back are unaffected. When the
//                     macro is undefined, issue is unconditional while
//                     running.
//
// Ports:
//   clk        in   clock
//   rst_n      in   synchronous active-low reset; clears every register
//   start      in   one-cycle pulse; begins a transform when idle
//   mem_rdy    in   (FFT_SEQ_STALL_EN only) memory ready for a new issue
//   busy       out  high from the cycle after an accepted start until done
//   done       out  one-cycle pulse once the last write of the last stage is done
//   rd_en      out  data-RAM dual read strobe
//   rd_addr_p  out  read address of xp
//   rd_addr_q  out  read address of xq
//   tw_addr    out  twiddle-ROM index k (W_N^k)
//   bf_en      out  butterfly enable, rd_en delayed RD_LAT cycles
//   bf_vld     in   butterfly result valid
//   wr_en      out  data-RAM dual write strobe (bf_vld with a non-empty queue)
//   wr_addr_p  out  write address of yp (head of the address queue)
//   wr_addr_q  out  write address of yq (head of the address queue)
//   stage      out  current stage index 0..N_LOG2-1
//   err        out  sticky; bf_vld with empty queue, or push into a full queue
// ---------------------------------------------------------------------------

module fft_bf_sequencer #(
  parameter int N_LOG2   = 8,
  parameter int RD_LAT   = 1,
  parameter int BF_LAT   = 3,
  parameter int AQ_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef FFT_SEQ_STALL_EN
  input  logic              mem_rdy,
`endif
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_p,
  output logic [N_LOG2-1:0] rd_addr_q,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              bf_en,
  input  logic              bf_vld,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_p,
  output logic [N_LOG2-1:0] wr_addr_q,
  output logic [2:0]        stage,
  output logic              err
);

  // Butterfly index width. The stage port is 3 bits wide, so N_LOG2 <= 8.
  localparam int JW = N_LOG2 - 1;
  localparam logic [2:0] LAST_STAGE = 3'(N_LOG2 - 1);
  localparam logic [JW:0] J_ONE = (JW+1)'(1);

  // The queue must hold every butterfly still in flight. Its size is never
  // allowed below the read+butterfly pipeline depth. The pointers wrap
  // explicitly, so the size need not be a power of two.
  localparam int AQ_MIN  = RD_LAT + BF_LAT + 1;
  localparam int AQ_SIZE = (AQ_DEPTH > AQ_MIN) ? AQ_DEPTH : AQ_MIN;
  localparam int PW      = (AQ_SIZE > 1) ? $clog2(AQ_SIZE) : 1;
  localparam int CW      = $clog2(AQ_SIZE + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(AQ_SIZE - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(AQ_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t            state_q;
  logic [JW:0]       jCnt_q;
  logic [2:0]        stage_q;
  logic              rdEn_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [N_LOG2-1:0] rdP_q;
  logic [N_LOG2-1:0] rdQ_q;
  logic [JW-1:0]     tw_q;
  logic [RD_LAT-1:0] rdPipe_q;
  logic [N_LOG2-1:0] outCnt_q;
  logic [N_LOG2-1:0] outCnt_d;

  logic [2*N_LOG2-1:0] aqMem_q [AQ_SIZE];
  logic [PW-1:0]       aqWr_q;
  logic [PW-1:0]       aqRd_q;
  logic [CW-1:0]       aqCnt_q;
  logic [CW-1:0]       aqCnt_d;
  logic                aqEmpty;
  logic                aqFull;
  logic                aqPush;
  logic                wrEn;
  logic                err_d;

  logic              rdy;
  logic              issue;
  logic              drainDone;
  logic [2:0]        issStage;
  logic [JW-1:0]     issJ;
  logic [JW-1:0]     kMask;
  logic [JW-1:0]     kIss;
  logic [JW-1:0]     hiIss;
  logic [JW-1:0]     twIss;
  logic [2:0]        twShift;
  logic [N_LOG2-1:0] pIss;
  logic [N_LOG2-1:0] qIss;

`ifdef FFT_SEQ_STALL_EN
  assign rdy = mem_rdy;
`else
  assign rdy = 1'b1;
`endif

  // Decide whether a butterfly is launched at the coming edge, and which
  // (stage, j) it is. The first butterfly of a stage goes out on the same edge
  // that leaves IDLE or DRAIN. Because of this, no cycle is lost entering RUN.
  // jCnt_q counts the butterflies already issued. Its top bit marks that the
  // whole stage is out.
  always_comb begin
    issue     = 1'b0;
    issStage  = stage_q;
    issJ      = jCnt_q[JW-1:0];
    drainDone = (outCnt_q == '0);
    case (state_q)
      IDLE: begin
        issue    = start & rdy;
        issStage = '0;
        issJ     = '0;
      end
      RUN: begin
        issue = ~jCnt_q[JW] & rdy;
      end
      DRAIN: begin
        if (drainDone && (stage_q != LAST_STAGE)) begin
          issue    = rdy;
          issStage = stage_q + 3'd1;
          issJ     = '0;
        end
      end
      default: begin
        issue = 1'b0;
      end
    endcase
  end

  // Butterfly addressing for stage s uses half = 2^s and k = j mod half.
  // Inserting a zero bit at position s of j yields p. q is p with that bit set.
  // The twiddle index is k scaled up to the full N/2 range.
  always_comb begin
    kMask   = ~({JW{1'b1}} << issStage);
    kIss    = issJ & kMask;
    hiIss   = issJ & ~kMask;
    pIss    = {hiIss, 1'b0} | {1'b0, kIss};
    qIss    = pIss | (N_LOG2'(1) << issStage);
    twShift = 3'(JW) - issStage;
    twIss   = kIss << twShift;
  end

  // Main sequencer. Every output it owns is registered here. The read address
  // and twiddle registers load only on an issue, and otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      jCnt_q  <= '0;
      stage_q <= '0;
      rdEn_q  <= 1'b0;
      rdP_q   <= '0;
      rdQ_q   <= '0;
      tw_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rdEn_q <= issue;
      if (issue) begin
        rdP_q <= pIss;
        rdQ_q <= qIss;
        tw_q  <= twIss;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            stage_q <= '0;
            jCnt_q  <= issue ? J_ONE : '0;
          end
        end
        RUN: begin
          if (jCnt_q[JW]) begin
            state_q <= DRAIN;
          end else if (issue) begin
            jCnt_q <= jCnt_q + J_ONE;
          end
        end
        DRAIN: begin
          if (drainDone) begin
            if (stage_q == LAST_STAGE) begin
              state_q <= FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= RUN;
              stage_q <= stage_q + 3'd1;
              jCnt_q  <= issue ? J_ONE : '0;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // A write happens only when the queue holds an address for the result.
  // A push into a full queue is dropped unless a pop frees a slot that same
  // cycle. Either anomaly raises the sticky error.
  assign aqEmpty = (aqCnt_q == '0);
  assign aqFull  = (aqCnt_q == CNT_FULL);
  assign wrEn    = bf_vld & ~aqEmpty;
  assign aqPush  = rdEn_q & (~aqFull | wrEn);
  assign err_d   = err_q | (bf_vld & aqEmpty) | (rdEn_q & aqFull & ~wrEn);

  // Queue occupancy and outstanding-butterfly count. A launch and a
  // completion in the same cycle cancel each other.
  always_comb begin
    aqCnt_d  = aqCnt_q;
    outCnt_d = outCnt_q;
    case ({aqPush, wrEn})
      2'b10:   aqCnt_d = aqCnt_q + CW'(1);
      2'b01:   aqCnt_d = aqCnt_q - CW'(1);
      default: aqCnt_d = aqCnt_q;
    endcase
    case ({rdEn_q, wrEn})
      2'b10:   outCnt_d = outCnt_q + N_LOG2'(1);
      2'b01:   outCnt_d = outCnt_q - N_LOG2'(1);
      default: outCnt_d = outCnt_q;
    endcase
  end

  // Datapath registers: the read-latency delay line that produces bf_en, the
  // write-address queue, the drain counter and the sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdPipe_q <= '0;
      outCnt_q <= '0;
      aqWr_q   <= '0;
      aqRd_q   <= '0;
      aqCnt_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < AQ_SIZE; i++) begin
        aqMem_q[i] <= '0;
      end
    end else begin
      rdPipe_q[0] <= rdEn_q;
      for (int i = 1; i < RD_LAT; i++) begin
        rdPipe_q[i] <= rdPipe_q[i-1];
      end
      if (aqPush) begin
        aqMem_q[aqWr_q] <= {rdP_q, rdQ_q};
        aqWr_q          <= (aqWr_q == PTR_LAST) ? '0 : aqWr_q + PW'(1);
      end
      if (wrEn) begin
        aqRd_q <= (aqRd_q == PTR_LAST) ? '0 : aqRd_q + PW'(1);
      end
      aqCnt_q  <= aqCnt_d;
      outCnt_q <= outCnt_d;
      err_q    <= err_d;
    end
  end

  // The queue head drives the write addresses directly. When the queue is
  // empty, the addresses read as zero.
  assign {wr_addr_p, wr_addr_q} = aqEmpty ? '0 : aqMem_q[aqRd_q];

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rdEn_q;
  assign rd_addr_p = rdP_q;
  assign rd_addr_q = rdQ_q;
  assign tw_addr   = tw_q;
  assign bf_en     = rdPipe_q[RD_LAT-1];
  assign wr_en     = wrEn;
  assign stage     = stage_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fft_bf_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_bf_sequencer
//
// Directed bench for fft_bf_sequencer. A three-stage butterfly model turns
// bf_en into bf_vld. Inputs change on the falling edge and outputs are sampled
// there as well. Each issued butterfly is logged so that directed address
// vectors can be checked once a transform is complete.
// ---------------------------------------------------------------------------

module tb_fft_bf_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [7:0] rd_addr_p;
  logic [7:0] rd_addr_q;
  logic [6:0] tw_addr;
  logic       bf_en;
  logic       bf_vld;
  logic       wr_en;
  logic [7:0] wr_addr_p;
  logic [7:0] wr_addr_q;
  logic [2:0] stage;
  logic       err;
`ifdef FFT_SEQ_STALL_EN
  logic       memRdy = 1'b1;
`endif

  logic [2:0] bfPipe = '0;
  logic       injVld = 1'b0;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   monOn    = 1'b0;
  logic expErr   = 1'b0;

  logic       histEn [1:4];
  logic [7:0] histP  [1:4];
  logic [7:0] histQ  [1:4];

  int logP     [1024];
  int logQ     [1024];
  int logTw    [1024];
  int logStage [1024];
  int logCyc   [1024];
  int nIss, nWr, nDone, lastWrCyc, lastS0WrCyc, doneCyc;
  int guard;

  always #5 clk = ~clk;

  fft_bf_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef FFT_SEQ_STALL_EN
    .mem_rdy   (memRdy),
`endif
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_p (rd_addr_p),
    .rd_addr_q (rd_addr_q),
    .tw_addr   (tw_addr),
    .bf_en     (bf_en),
    .bf_vld    (bf_vld),
    .wr_en     (wr_en),
    .wr_addr_p (wr_addr_p),
    .wr_addr_q (wr_addr_q),
    .stage     (stage),
    .err       (err)
  );

  // Butterfly model with a three-cycle latency. It is flushed by reset, so an
  // aborted transform leaves no results in flight.
  always @(posedge clk) begin
    if (!rst_n) bfPipe <= '0;
    else        bfPipe <= {bfPipe[1:0], bf_en};
  end
  assign bf_vld = bfPipe[2] | injVld;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clearHist();
    for (int i = 1; i <= 4; i++) begin
      histEn[i] = 1'b0;
      histP[i]  = '0;
      histQ[i]  = '0;
    end
  endtask

  task automatic clearLog();
    nIss = 0; nWr = 0; nDone = 0;
    lastWrCyc = 0; lastS0WrCyc = 0; doneCyc = 0;
  endtask

  // Per-cycle observation. bf_en must repeat the rd_en of the previous cycle,
  // and each write must carry the addresses read four cycles earlier.
  task automatic monitorCycle();
    cyc++;
    if (monOn) begin
      checkOutput("bf_en_follows_rd_en", 32'(bf_en), 32'(histEn[1]));
      checkOutput("wr_en_vs_issue", 32'(wr_en), 32'(histEn[4]));
      if (wr_en === 1'b1) begin
        checkOutput("wr_addr_p_vs_issue", 32'(wr_addr_p), 32'(histP[4]));
        checkOutput("wr_addr_q_vs_issue", 32'(wr_addr_q), 32'(histQ[4]));
      end
      checkOutput("err_level", 32'(err), 32'(expErr));
    end
    for (int i = 4; i > 1; i--) begin
      histEn[i] = histEn[i-1];
      histP[i]  = histP[i-1];
      histQ[i]  = histQ[i-1];
    end
    histEn[1] = rd_en;
    histP[1]  = rd_addr_p;
    histQ[1]  = rd_addr_q;
    if (rd_en === 1'b1) begin
      if (nIss < 1024) begin
        logP[nIss]     = int'(rd_addr_p);
        logQ[nIss]     = int'(rd_addr_q);
        logTw[nIss]    = int'(tw_addr);
        logStage[nIss] = int'(stage);
        logCyc[nIss]   = cyc;
      end
      nIss++;
    end
    if (wr_en === 1'b1) begin
      nWr++;
      lastWrCyc = cyc;
      if (nWr == 128) lastS0WrCyc = cyc;
    end
    if (done === 1'b1) begin
      nDone++;
      doneCyc = cyc;
      if (monOn) checkOutput("busy_low_with_done", 32'(busy), 32'd0);
    end
  endtask

  task automatic applyStimulus(input logic rstnV, input logic startV, input logic injV);
    rst_n  = rstnV;
    start  = startV;
    injVld = injV;
    @(negedge clk);
    monitorCycle();
  endtask

  task automatic checkIssue(input string tag, input int p, input int q, input int tw);
    checkOutput({tag, "_rd_en"}, 32'(rd_en), 32'd1);
    checkOutput({tag, "_p"}, 32'(rd_addr_p), 32'(p));
    checkOutput({tag, "_q"}, 32'(rd_addr_q), 32'(q));
    checkOutput({tag, "_tw"}, 32'(tw_addr), 32'(tw));
  endtask

  task automatic checkLogged(input string tag, input int idx, input int s, input int p, input int q, input int tw);
    checkOutput({tag, "_stage"}, 32'(logStage[idx]), 32'(s));
    checkOutput({tag, "_p"}, 32'(logP[idx]), 32'(p));
    checkOutput({tag, "_q"}, 32'(logQ[idx]), 32'(q));
    checkOutput({tag, "_tw"}, 32'(logTw[idx]), 32'(tw));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    checkOutput({tag, "_rd_addr_p"}, 32'(rd_addr_p), 32'd0);
    checkOutput({tag, "_rd_addr_q"}, 32'(rd_addr_q), 32'd0);
    checkOutput({tag, "_tw_addr"}, 32'(tw_addr), 32'd0);
    checkOutput({tag, "_bf_en"}, 32'(bf_en), 32'd0);
    checkOutput({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    checkOutput({tag, "_wr_addr_p"}, 32'(wr_addr_p), 32'd0);
    checkOutput({tag, "_wr_addr_q"}, 32'(wr_addr_q), 32'd0);
    checkOutput({tag, "_stage"}, 32'(stage), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic runToDone(input string tag);
    guard = 0;
    while (nDone == 0 && guard < 4000) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      guard++;
    end
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput({tag, "_done_count"}, 32'(nDone), 32'd1);
    checkOutput({tag, "_issue_count"}, 32'(nIss), 32'd1024);
    checkOutput({tag, "_write_count"}, 32'(nWr), 32'd1024);
    checkOutput({tag, "_done_after_last_wr"}, 32'(doneCyc > lastWrCyc), 32'd1);
    checkOutput({tag, "_done_near_last_wr"}, 32'(doneCyc <= lastWrCyc + 3), 32'd1);
    checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    clearHist();
    clearLog();

    // Reset state: every output reads zero.
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkAllZero("reset");

    // First transform: the opening issues of stage 0.
    monOn = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkIssue("s0_j0", 0, 1, 0);
    checkOutput("s0_j0_busy", 32'(busy), 32'd1);
    checkOutput("s0_j0_stage", 32'(stage), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkIssue("s0_j1", 2, 3, 0);
    checkOutput("s0_j1_bf_en", 32'(bf_en), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkIssue("s0_j2", 4, 5, 0);

    // A start pulse while busy must not disturb the sequence.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkIssue("s0_j3_start_busy", 6, 7, 0);
    runToDone("run1");

    for (int j = 0; j < 128; j++) begin
      checkLogged($sformatf("run1_s0_j%0d", j), j, 0, 2*j, 2*j+1, 0);
    end
    checkLogged("s1_j0", 128, 1, 0, 2, 0);
    checkLogged("s1_j1", 129, 1, 1, 3, 64);
    checkLogged("s1_j2", 130, 1, 4, 6, 0);
    checkOutput("s1_after_s0_writes", 32'(logCyc[128] > lastS0WrCyc), 32'd1);
    checkLogged("s7_j5", 7*128+5, 7, 5, 133, 5);
    checkLogged("s7_j127", 1023, 7, 127, 255, 127);

    // A spurious bf_vld while idle must not write, and it must set sticky err.
    monOn = 1'b0;
    injVld = 1'b1;
    #1;
    checkOutput("spurious_wr_en", 32'(wr_en), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("spurious_err_set", 32'(err), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("spurious_err_held", 32'(err), 32'd1);
    checkOutput("spurious_wr_en_after", 32'(wr_en), 32'd0);

    // Reset in the middle of stage 3 aborts the transform without a done.
    clearLog();
    clearHist();
    expErr = 1'b1;
    monOn  = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    guard = 0;
    while (!(stage == 3'd3 && nIss >= 3*128 + 20) && guard < 3000) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      guard++;
    end
    checkOutput("reached_stage3", 32'(stage), 32'd3);
    monOn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkAllZero("midreset");
    clearHist();
    expErr = 1'b0;
    monOn  = 1'b1;
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("midreset_no_done", 32'(nDone), 32'd0);
    checkOutput("midreset_idle_busy", 32'(busy), 32'd0);

    // A new start after the abort replays stage 0 from the beginning.
    clearLog();
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkIssue("rerun_j0", 0, 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkIssue("rerun_j1", 2, 3, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkIssue("rerun_j2", 4, 5, 0);
    runToDone("run2");

`ifdef FFT_SEQ_STALL_EN
    // With mem_rdy toggling, issues are spaced out but no j is skipped or
    // repeated.
    monOn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    clearHist();
    clearLog();
    monOn  = 1'b1;
    memRdy = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkIssue("stall_c0", 0, 1, 0);
    memRdy = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("stall_c1_rd_en", 32'(rd_en), 32'd0);
    memRdy = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkIssue("stall_c2", 2, 3, 0);
    memRdy = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("stall_c3_rd_en", 32'(rd_en), 32'd0);
    memRdy = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkIssue("stall_c4", 4, 5, 0);
    runToDone("stall_run");
    for (int j = 0; j < 128; j++) begin
      checkLogged($sformatf("stall_s0_j%0d", j), j, 0, 2*j, 2*j+1, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_bf_sequencer.md
Name: fft_bf_sequencer

Overview:
- Control block for the in-place 256-point radix-2 DIT FFT.
- Issues butterfly operations to the butterfly core, stage by stage; input data is held in bit-reversed order.
- Generates the data-RAM read addresses, the twiddle-ROM address and the butterfly enable.
- Consumes the butterfly valid and writes the results back to the same p/q addresses, draining the pipeline between stages to avoid read-after-write hazards.

Parameters:
- N_LOG2, 8, log2 of FFT length (N=256; 128 butterflies per stage, N_LOG2 stages)
- RD_LAT, 1, data-RAM/twiddle-ROM read latency in cycles (fixed 1)
- BF_LAT, 3, butterfly latency: bf_en high at cycle t -> bf_vld high at t+3
- AQ_DEPTH, 8, write-address queue depth (power of 2, >= RD_LAT+BF_LAT+1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- start  in  1  one-cycle pulse; begins a transform when idle
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when the last write of the last stage completes
- rd_en  out  1  data-RAM dual read strobe
- rd_addr_p  out  N_LOG2  read address of xp
- rd_addr_q  out  N_LOG2  read address of xq
- tw_addr  out  N_LOG2-1  twiddle-ROM index k (W_N^k)
- bf_en  out  1  butterfly enable; equals rd_en delayed RD_LAT cycles
- bf_vld  in  1  butterfly result valid
- wr_en  out  1  data-RAM dual write strobe (= bf_vld when queue non-empty)
- wr_addr_p  out  N_LOG2  write address of yp
- wr_addr_q  out  N_LOG2  write address of yq
- stage  out  3  current stage index 0..N_LOG2-1
- err  out  1  sticky: bf_vld seen with empty address queue, or queue overflow

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all registers to 0.
  - All outputs read 0; FSM goes to IDLE; queue is emptied.
  - Reset mid-transform aborts it; no done is generated.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE: start=1 -> RUN, with stage=0, j=0, busy=1. start while busy is ignored.
  - RUN: rd_en=1 every cycle.
    - When j=127 is issued -> DRAIN; otherwise j increments.
  - DRAIN: rd_en=0; wait until outstanding count = 0 (all writes of the stage done).
    - If stage < N_LOG2-1: stage+1, j=0 -> RUN.
    - Else -> FIN.
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
- Address generation, stage s, butterfly j (0..127):
  - half = 2^s; k = j mod half.
  - p = (j>>s)*2*half + k; q = p + half.
  - tw_addr = k << (N_LOG2-1-s).
  - All outputs are registered, valid in the cycle rd_en=1.
- Alignment:
  - bf_en is rd_en delayed RD_LAT cycles (registered pipe).
  - {p,q} are pushed into the address queue when rd_en=1.
  - The queue head drives wr_addr_p/q combinationally; it is popped when bf_vld=1.
- wr_en = bf_vld & ~queue_empty.
  - bf_vld with an empty queue sets err; no write is issued.
  - err clears only on reset.
- Outstanding counter (width N_LOG2):
  - +1 on rd_en, -1 on wr_en; both in the same cycle leaves it unchanged.
  - Push into a full queue sets err; it cannot occur in correct operation.
- Throughput: one butterfly per cycle within a stage.
  - Per-stage overhead = RD_LAT+BF_LAT+2 drain cycles.
  - Total for N=256: 8*128 issue cycles + 8 drains + 1 FIN.

Optional Feature:
- Macro FFT_SEQ_STALL_EN.
- When defined:
  - Adds input mem_rdy (1 bit).
  - In RUN, a butterfly is issued (rd_en=1, j advances) only in cycles with mem_rdy=1; otherwise rd_en=0 and j holds.
  - DRAIN and write-back are unaffected.
- When undefined: no mem_rdy port; issue is unconditional every RUN cycle.

Test Plan:
- start pulse after reset:
  - rd_en first high in the cycle after start; busy=1.
  - First three issues: (p,q,tw) = (0,1,0), (2,3,0), (4,5,0).
  - bf_en follows each rd_en by 1 cycle.
- Stage 1 (stage=1): j=0 -> (0,2,0); j=1 -> (1,3,64); j=2 -> (4,6,0).
  - First stage-1 rd_en occurs only after the last stage-0 wr_en.
- Stage 7: j=5 -> (5,133,5); j=127 -> (127,255,127).
  - done pulses exactly once after the 1024th wr_en; busy drops with done.
- Model butterfly with BF_LAT=3 feeding bf_vld:
  - Every wr_addr_p/q equals the rd_addr_p/q issued 4 cycles earlier.
  - err stays 0.
- Inject a spurious bf_vld while IDLE -> wr_en=0, err=1 and held; start pulse while busy -> ignored, sequence unchanged.
- rst_n=0 for one cycle mid-stage 3 -> next cycle all outputs 0, FSM IDLE, no done; a new start produces the stage-0 sequence again.
- With FFT_SEQ_STALL_EN: mem_rdy toggling 1,0,1,0 -> issues at cycles 0,2,4 with (0,1,0), (2,3,0), (4,5,0); no skipped or duplicated j.
